// File: rtl/instruction_fetch_stage_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instruction_fetch_stage_pkg: widths and constants shared by the fetch stage.
// Rev 1.0
// ---------------------------------------------------------------------------
package instruction_fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTRUCTION  = 32'h0000_0013;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [ILEN-1:0] instr_t;

  function automatic addr_t word_align(input addr_t a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_stage_reservation_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_reservation_buffer: in-order staging of fetched words with their PCs.
// Rev 1.0
// ---------------------------------------------------------------------------
module fetch_reservation_buffer
  import instruction_fetch_stage_pkg::*;
#(
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          flush,
  input  logic                          alloc,
  input  addr_t                         alloc_pc,
  input  logic                          rsp_valid,
  input  instr_t                        rsp_data,
  input  logic                          pop,
  output logic [$clog2(BUFFER_DEPTH):0] reserved,
  output logic                          head_valid,
  output addr_t                         head_pc,
  output instr_t                        head_instr
);

  localparam int PTR_W     = $clog2(BUFFER_DEPTH);
  localparam int DISCARD_W = PTR_W + 4;
  localparam logic [PTR_W:0]     c_ptr_one     = (PTR_W+1)'(1);
  localparam logic [DISCARD_W-1:0] c_discard_one = DISCARD_W'(1);

  addr_t                 r_pc    [BUFFER_DEPTH];
  instr_t                r_instr [BUFFER_DEPTH];
  logic [BUFFER_DEPTH-1:0] r_filled;
  logic [PTR_W:0]        r_head, r_fill, r_alloc;
  logic [DISCARD_W-1:0]  r_discard;

  logic [PTR_W-1:0] w_head_idx, w_fill_idx, w_alloc_idx;
  logic [PTR_W:0]   w_unfilled;
  logic             w_accept;

  assign w_head_idx  = r_head[PTR_W-1:0];
  assign w_fill_idx  = r_fill[PTR_W-1:0];
  assign w_alloc_idx = r_alloc[PTR_W-1:0];
  assign reserved    = r_alloc - r_head;
  assign w_unfilled  = r_alloc - r_fill;
  assign w_accept    = rsp_valid && (r_discard == '0) && !flush;

  // Filled bits are cleared on allocation, so a stale bit is harmless once flushed.
  assign head_valid = (reserved != '0) && r_filled[w_head_idx];
  assign head_pc    = r_pc[w_head_idx];
  assign head_instr = r_instr[w_head_idx];

  always_ff @(posedge CLK) begin
    if (alloc)    r_pc[w_alloc_idx]   <= alloc_pc;
    if (w_accept) r_instr[w_fill_idx] <= rsp_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_head    <= '0;
      r_fill    <= '0;
      r_alloc   <= '0;
      r_filled  <= '0;
      r_discard <= '0;
    end else if (flush) begin
      r_head    <= r_alloc;
      r_fill    <= r_alloc;
      // Words still owed by memory: earlier discards plus this path's unfilled entries.
      r_discard <= r_discard + DISCARD_W'(w_unfilled) - DISCARD_W'(rsp_valid);
    end else begin
      if (alloc) begin
        r_alloc               <= r_alloc + c_ptr_one;
        r_filled[w_alloc_idx] <= 1'b0;
      end
      if (w_accept) begin
        r_fill               <= r_fill + c_ptr_one;
        r_filled[w_fill_idx] <= 1'b1;
      end else if (rsp_valid) begin
        r_discard <= r_discard - c_discard_one;
      end
      if (pop) r_head <= r_head + c_ptr_one;
    end
  end

`ifndef SYNTHESIS
  assert property (@(posedge CLK) disable iff (RST)
    rsp_valid |-> ((r_discard != '0) || (w_unfilled != '0)));
`endif

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instruction_fetch_stage: PC register, imem request issue and decode output.
// Rev 1.0
// ---------------------------------------------------------------------------
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int              BUFFER_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            STALL_FETCH_STAGE,
  input  logic            BRANCH_TAKEN,
  input  logic [XLEN-1:0] BRANCH_TARGET,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_READY,
  input  logic            IMEM_RVALID,
  input  logic [ILEN-1:0] IMEM_RDATA,
  output logic [ILEN-1:0] INSTRUCTION,
  output logic [XLEN-1:0] PC_OUT,
  output logic            INSTRUCTION_VALID
);

  localparam int CNT_W = $clog2(BUFFER_DEPTH) + 1;
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(BUFFER_DEPTH);

  addr_t            r_pc;
  logic [CNT_W-1:0] w_reserved;
  logic             w_head_valid;
  addr_t            w_head_pc;
  instr_t           w_head_instr;
  logic             w_pop;
  logic             w_fire;

  // A pop this cycle frees a slot, so a full buffer can still issue.
  assign w_pop     = w_head_valid && !STALL_FETCH_STAGE && !BRANCH_TAKEN;
  assign IMEM_REQ  = !RST && !BRANCH_TAKEN && ((w_reserved - CNT_W'(w_pop)) < c_depth);
  assign IMEM_ADDR = r_pc;
  assign w_fire    = IMEM_REQ && IMEM_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)               r_pc <= word_align(RESET_PC);
    else if (BRANCH_TAKEN) r_pc <= word_align(BRANCH_TARGET);
    else if (w_fire)       r_pc <= r_pc + 32'd4;
  end

  fetch_reservation_buffer #(
    .BUFFER_DEPTH (BUFFER_DEPTH)
  ) u_buffer (
    .CLK        (CLK),
    .RST        (RST),
    .flush      (BRANCH_TAKEN),
    .alloc      (w_fire),
    .alloc_pc   (r_pc),
    .rsp_valid  (IMEM_RVALID),
    .rsp_data   (IMEM_RDATA),
    .pop        (w_pop),
    .reserved   (w_reserved),
    .head_valid (w_head_valid),
    .head_pc    (w_head_pc),
    .head_instr (w_head_instr)
  );

  assign INSTRUCTION_VALID = w_head_valid;
  assign INSTRUCTION       = w_head_valid ? w_head_instr : NOP_INSTRUCTION;
  assign PC_OUT            = w_head_valid ? w_head_pc : '0;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_instruction_fetch_stage: directed bench with a fixed-latency memory.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_instruction_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        STALL_FETCH_STAGE = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = 32'h0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READY = 1'b1;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC_OUT;
  logic        INSTRUCTION_VALID;

  int tests = 0;
  int fails = 0;
  int mem_lat = 1;

  logic        pv [8];
  logic [31:0] pa [8];

  always #5 CLK = ~CLK;

  instruction_fetch_stage #(
    .RESET_PC     (32'h0000_1000),
    .BUFFER_DEPTH (4)
  ) dut (
    .CLK               (CLK),
    .RST               (RST),
    .STALL_FETCH_STAGE (STALL_FETCH_STAGE),
    .BRANCH_TAKEN      (BRANCH_TAKEN),
    .BRANCH_TARGET     (BRANCH_TARGET),
    .IMEM_REQ          (IMEM_REQ),
    .IMEM_ADDR         (IMEM_ADDR),
    .IMEM_READY        (IMEM_READY),
    .IMEM_RVALID       (IMEM_RVALID),
    .IMEM_RDATA        (IMEM_RDATA),
    .INSTRUCTION       (INSTRUCTION),
    .PC_OUT            (PC_OUT),
    .INSTRUCTION_VALID (INSTRUCTION_VALID)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hABCD_0000;
  endfunction

  // Memory: in-order, fixed latency of mem_lat cycles, shares RST.
  assign IMEM_RVALID = pv[0];
  assign IMEM_RDATA  = word_of(pa[0]);

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 8; i++) pv[i] <= 1'b0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        pv[i] <= pv[i+1];
        pa[i] <= pa[i+1];
      end
      pv[7] <= 1'b0;
      pv[mem_lat-1] <= IMEM_REQ && IMEM_READY;
      pa[mem_lat-1] <= IMEM_ADDR;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic stall, input logic br, input logic [31:0] tgt);
    @(negedge CLK);
    STALL_FETCH_STAGE = stall;
    BRANCH_TAKEN      = br;
    BRANCH_TARGET     = tgt;
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, ".valid"}, {31'b0, INSTRUCTION_VALID}, 32'd1);
    chk({tag, ".pc"}, PC_OUT, pc);
    chk({tag, ".instr"}, INSTRUCTION, word_of(pc));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".valid"}, {31'b0, INSTRUCTION_VALID}, 32'd0);
    chk({tag, ".instr"}, INSTRUCTION, 32'h0000_0013);
    chk({tag, ".pc"}, PC_OUT, 32'h0);
  endtask

  task automatic do_reset(input int lat);
    @(negedge CLK);
    RST = 1'b1;
    STALL_FETCH_STAGE = 1'b0;
    BRANCH_TAKEN = 1'b0;
    mem_lat = lat;
    @(negedge CLK);
    #1;
    chk("rst.req", {31'b0, IMEM_REQ}, 32'd0);
    chk_empty("rst");
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("c0.req", {31'b0, IMEM_REQ}, 32'd1);
    chk("c0.addr", IMEM_ADDR, 32'h0000_1000);
    chk_empty("c0");
  endtask

  initial begin
    // Back-to-back fetch, 1-cycle memory
    do_reset(1);
    cyc(0, 0, 0);
    chk("t1.c1.addr", IMEM_ADDR, 32'h0000_1004);
    chk("t1.c1.valid", {31'b0, INSTRUCTION_VALID}, 32'd0);
    cyc(0, 0, 0);
    chk("t1.c2.addr", IMEM_ADDR, 32'h0000_1008);
    chk_head("t1.c2", 32'h0000_1000);
    cyc(0, 0, 0);
    chk_head("t1.c3", 32'h0000_1004);
    cyc(0, 0, 0);
    chk_head("t1.c4", 32'h0000_1008);

    // Stall for 5 cycles: head holds, buffer fills to 4 then issue stops
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 0);
      chk_head("t2.stall", 32'h0000_100C);
      chk("t2.stall.req", {31'b0, IMEM_REQ}, (k < 2) ? 32'd1 : 32'd0);
      if (k < 2) chk("t2.stall.addr", IMEM_ADDR, 32'h0000_1014 + 32'(4 * k));
    end
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0);
      chk_head("t2.release", 32'h0000_100C + 32'(4 * k));
      if (k == 0) begin
        chk("t2.release.req", {31'b0, IMEM_REQ}, 32'd1);
        chk("t2.release.addr", IMEM_ADDR, 32'h0000_101C);
      end
    end

    // Redirect with 3-cycle memory, 3 old responses owed
    do_reset(3);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 32'h0000_2002);
    chk("t3.br.req", {31'b0, IMEM_REQ}, 32'd0);
    cyc(0, 0, 0);
    chk("t3.tgt.req", {31'b0, IMEM_REQ}, 32'd1);
    chk("t3.tgt.addr", IMEM_ADDR, 32'h0000_2000);
    chk_empty("t3.c4");
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0);
      chk_empty("t3.wait");
    end

    // Redirect + same-cycle response + stall while head is valid
    cyc(1, 1, 32'h0000_3000);
    chk_head("t4.br", 32'h0000_2000);
    chk("t4.br.req", {31'b0, IMEM_REQ}, 32'd0);
    cyc(1, 0, 0);
    chk_empty("t4.c9");
    chk("t4.c9.req", {31'b0, IMEM_REQ}, 32'd1);
    chk("t4.c9.addr", IMEM_ADDR, 32'h0000_3000);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0);
      chk_empty("t4.drop");
    end
    cyc(0, 0, 0);
    chk_head("t4.c13", 32'h0000_3000);

    // PC wraps from 0xFFFF_FFFC to 0; target low bits ignored
    cyc(0, 1, 32'hFFFF_FFFF);
    cyc(0, 0, 0);
    chk("t5.addr0", IMEM_ADDR, 32'hFFFF_FFFC);
    chk("t5.req0", {31'b0, IMEM_REQ}, 32'd1);
    chk_empty("t5.c15");
    cyc(0, 0, 0);
    chk("t5.addr1", IMEM_ADDR, 32'h0000_0000);
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 0);
      chk_empty("t5.wait");
    end
    cyc(0, 0, 0);
    chk_head("t5.c19", 32'hFFFF_FFFC);
    cyc(0, 0, 0);
    chk_head("t5.c20", 32'h0000_0000);

    // Asynchronous reset mid-stream
    cyc(0, 0, 0);
    chk_head("t6.pre", 32'h0000_0004);
    #1;
    RST = 1'b1;
    #1;
    chk("t6.rst.req", {31'b0, IMEM_REQ}, 32'd0);
    chk_empty("t6.rst");
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("t6.c0.req", {31'b0, IMEM_REQ}, 32'd1);
    chk("t6.c0.addr", IMEM_ADDR, 32'h0000_1000);
    chk_empty("t6.c0");
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0);
      chk_empty("t6.wait");
    end
    cyc(0, 0, 0);
    chk_head("t6.c4", 32'h0000_1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Upstream neighbour of the decoding stage. Owns the program counter, issues in-order word fetches to instruction memory over a request/ready + response-valid handshake, and stages returned words with their PCs in a small reservation buffer. Presents one instruction per cycle to decode, honours the decode stall, and redirects on a taken branch/jump, discarding in-flight responses that belong to the old path.

## Interface
- RESET_PC, 32'h0000_0000: PC after reset; bits [1:0] must be 0.
- BUFFER_DEPTH, 4: reservation-buffer entries; power of two, ≥2.

- CLK  input  1  single clock; all state on rising edge.
- RST  input  1  asynchronous, active-high reset.
- STALL_FETCH_STAGE  input  1  decode cannot accept; hold head entry.
- BRANCH_TAKEN  input  1  redirect request from execute.
- BRANCH_TARGET  input  32  redirect address; bits [1:0] ignored (forced 0).
- IMEM_REQ  output  1  fetch request valid.
- IMEM_ADDR  output  32  fetch word address (= PC).
- IMEM_READY  input  1  memory accepts request this cycle.
- IMEM_RVALID  input  1  response word valid; in request order, latency ≥1.
- IMEM_RDATA  input  32  response word.
- INSTRUCTION  output  32  head instruction; NOP 32'h0000_0013 when not valid.
- PC_OUT  output  32  PC of head instruction; 0 when not valid.
- INSTRUCTION_VALID  output  1  head entry filled and not flushed.

## Operation
- Clock CLK, reset RST asynchronous active-high. During/after reset: PC=RESET_PC, buffer empty, discard count 0, IMEM_REQ=0, INSTRUCTION=32'h0000_0013, PC_OUT=0, INSTRUCTION_VALID=0. Memory shares RST; no pre-reset response may arrive afterwards.
- Buffer entry = {pc, instr, filled}. Three pointers: head (pop), fill (next response), alloc (next request). reserved = alloc−head, range 0..BUFFER_DEPTH.
- pop = INSTRUCTION_VALID && !STALL_FETCH_STAGE.
- Issue: IMEM_REQ = !BRANCH_TAKEN && (reserved − pop) < BUFFER_DEPTH. IMEM_ADDR = PC. Handshake fires on IMEM_REQ && IMEM_READY: allocate entry with pc=PC, filled=0; PC ← PC+4 (mod 2^32, 32'hFFFF_FFFC → 0). IMEM_REQ may deassert or change address without READY; memory treats each cycle independently.
- Response: IMEM_RVALID with discard count 0 writes IMEM_RDATA into fill entry, sets filled, advances fill. With discard count >0, the word is dropped and the count decrements.
- Output: INSTRUCTION/PC_OUT/INSTRUCTION_VALID driven combinationally from head entry. pop advances head.
- Redirect (BRANCH_TAKEN=1): PC ← {BRANCH_TARGET[31:2],2'b00}; all entries invalidated (head=fill=alloc); no request issued; no pop; discard ← (alloc−fill) − IMEM_RVALID, the same-cycle response being dropped. INSTRUCTION_VALID=0 from next cycle until the first new-path word fills.
- Redirect with STALL_FETCH_STAGE=1: redirect wins; head is flushed.
- Response and pop in the same cycle: both take effect; an entry filled this cycle is not poppable until next cycle.
- Responses with no unfilled reserved entry and discard 0 are a protocol error: assertion only, no defined behaviour.

## Timing
- Request→head latency = memory latency + 1 cycle (response registered in buffer).
- 1-cycle memory with READY=1 and no stall: one instruction per cycle after 2-cycle fill; any BUFFER_DEPTH ≥2 sustains this.
- Redirect penalty: target request issued the cycle after BRANCH_TAKEN; target instruction valid at memory latency + 2 cycles after BRANCH_TAKEN.
- Stall holds head outputs stable; requests continue until the buffer is fully reserved.

## Structure
- Shared package: NOP_INSTRUCTION (32'h0000_0013), XLEN (32), RESET_PC default, instruction-word width.
- One natural sub-module: fetch_reservation_buffer (pointers, filled bits, flush, discard counter). PC register and issue logic stay at top.

## Test plan
- Reset with RESET_PC=32'h0000_1000, 1-cycle memory, READY=1 -> IMEM_ADDR 0x1000, 0x1004, 0x1008 on consecutive cycles; INSTRUCTION_VALID high from cycle 2 with matching PC_OUT; no bubbles.
- STALL_FETCH_STAGE high 5 cycles, DEPTH=4 -> head PC/instr constant; exactly 4 entries reserved, IMEM_REQ low afterward; release -> next 4 PCs in order, none lost or duplicated.
- 3-cycle memory latency, BRANCH_TAKEN with target 0x2002 while 3 requests in flight -> 3 old responses dropped; next request address 0x2000; first valid output PC_OUT=0x2000.
- BRANCH_TAKEN in the same cycle as IMEM_RVALID and a stall -> response dropped, discard = outstanding−1, head flushed, no stale word ever valid.
- PC at 32'hFFFF_FFFC -> next request 0x0000_0000.
- Assert RST mid-stream with 2 requests outstanding -> outputs return immediately to NOP/0/0; after release, first request address = RESET_PC.
